qc_ldpc_row_expander: RTL and testbench

- Streams the expanded parity-check connections of one QC-LDPC base-matrix layer to the ECC decoder/encoder datapath.
- Holds the circulant shift table internally as ROM.
- On request, walks every sub-row of a selected block row and emits the absolute code-column index of each '1'.
- Generalises the fixed two-row shift register: circulant size, column count and row count are parametrised, absent circulants are supported, and output uses a valid/ready stream.

---
 rtl/qc_ldpc_row_expander_if.sv | 32 +++
 rtl/qc_ldpc_row_expander.sv | 198 +++++++++++++++++++
 tb/tb_qc_ldpc_row_expander.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qc_ldpc_row_expander_if.sv
// Request/stream bundle between a layer scheduler and the QC-LDPC row expander.
// The expander side uses the slave modport; the scheduler/consumer uses master.
interface qc_ldpc_row_expander_if #(
    parameter int unsigned ROW_W   = 1,
    parameter int unsigned SHIFT_W = 9,
    parameter int unsigned COL_W   = 14,
    parameter int unsigned BCOL_W  = 5
);
    logic               start;
    logic [ROW_W-1:0]   row_sel;
    logic               abort;
    logic               busy;
    logic               done;
    logic               err;
    logic               out_valid;
    logic               out_ready;
    logic [BCOL_W-1:0]  out_bcol;
    logic [SHIFT_W-1:0] out_sub;
    logic [SHIFT_W-1:0] out_shift;
    logic [COL_W-1:0]   out_col;
    logic               out_last;

    modport slave (
        input  start, row_sel, abort, out_ready,
        output busy, done, err, out_valid, out_bcol, out_sub, out_shift, out_col, out_last
    );

    modport master (
        output start, row_sel, abort, out_ready,
        input  busy, done, err, out_valid, out_bcol, out_sub, out_shift, out_col, out_last
    );
endinterface

// File: rtl/qc_ldpc_row_expander.sv
// QC-LDPC base-matrix row expander: walks every sub-row of one block row held
// in an internal shift ROM and streams the absolute code-column of each '1'.
// ROM entry (r,c) = {present, shift}, field index r*NB_COL+c, LSB-first.
module qc_ldpc_row_expander #(
    parameter int unsigned Z       = 512,
    parameter int unsigned SHIFT_W = 9,
    parameter int unsigned NB_COL  = 18,
    parameter int unsigned NB_ROW  = 2,
    parameter int unsigned ROW_W   = 1,
    parameter int unsigned COL_W   = 14,
    parameter int unsigned BCOL_W  = 5,
    parameter logic [NB_ROW*NB_COL*(SHIFT_W+1)-1:0] TABLE = {
        // row 1, bcol 17 .. 0
        10'd544, 10'd646, 10'd731, 10'd906, 10'd603, 10'd975, 10'd691, 10'd725, 10'd841,
        10'd959, 10'd687, 10'd1023, 10'd528, 10'd566, 10'd655, 10'd882, 10'd879, 10'd893,
        // row 0, bcol 17 .. 0
        10'd622, 10'd679, 10'd640, 10'd844, 10'd602, 10'd999, 10'd730, 10'd581, 10'd564,
        10'd533, 10'd986, 10'd977, 10'd822, 10'd1013, 10'd663, 10'd522, 10'd512, 10'd634
    }
) (
    input logic clk,
    input logic rst_n,
    qc_ldpc_row_expander_if.slave bus
);
    localparam int unsigned EW = SHIFT_W + 1;
    localparam logic [SHIFT_W:0]   Z_EXT    = EW'(Z);
    localparam logic [SHIFT_W-1:0] SUB_MAX  = SHIFT_W'(Z - 1);
    localparam logic [BCOL_W-1:0]  BCOL_MAX = BCOL_W'(NB_COL - 1);
    localparam logic [COL_W-1:0]   Z_COL    = COL_W'(Z);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, FIN} state_t;

    state_t state, state_next;

    logic [ROW_W-1:0]   row;
    logic [SHIFT_W-1:0] sub;
    logic [BCOL_W-1:0]  bcol;
    logic [COL_W-1:0]   base;
    logic               err_flag;

    logic               valid_q, last_q, done_q, err_q;
    logic [BCOL_W-1:0]  bcol_q;
    logic [SHIFT_W-1:0] sub_q, shift_q;
    logic [COL_W-1:0]   col_q;

    logic               row_ok, row_any;
    logic [BCOL_W-1:0]  last_bcol;
    logic [EW-1:0]      cur_entry;
    logic               cur_present;
    logic [SHIFT_W-1:0] cur_shift;
    logic [SHIFT_W:0]   sum;
    logic [SHIFT_W-1:0] sum_mod;
    logic [COL_W-1:0]   col_next;

    logic load_row, init_scan, scan, flush, fin_pulse;

    // ROM decode for the latched row: validity, any-present, highest present bcol, current entry
    always_comb begin
        row_ok    = (32'(row) < NB_ROW);
        row_any   = 1'b0;
        last_bcol = '0;
        cur_entry = '0;
        if (row_ok) begin
            for (int unsigned c = 0; c < NB_COL; c++) begin
                if (TABLE[(32'(row) * NB_COL + c) * EW + SHIFT_W]) begin
                    row_any   = 1'b1;
                    last_bcol = BCOL_W'(c);
                end
            end
            cur_entry = TABLE[(32'(row) * NB_COL + 32'(bcol)) * EW +: EW];
        end
    end

    assign cur_present = cur_entry[SHIFT_W];
    assign cur_shift   = cur_entry[SHIFT_W-1:0];

    // Column of the current entry: (shift+sub) mod Z by one conditional subtract, plus running bcol*Z
    always_comb begin
        sum      = {1'b0, cur_shift} + {1'b0, sub};
        sum_mod  = SHIFT_W'((sum >= Z_EXT) ? (sum - Z_EXT) : sum);
        col_next = base + COL_W'(sum_mod);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control; abort wins over any handshake
    always_comb begin
        state_next = state;
        load_row   = 1'b0;
        init_scan  = 1'b0;
        scan       = 1'b0;
        flush      = 1'b0;
        fin_pulse  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = CHECK;
                    load_row   = 1'b1;
                end
            end
            CHECK: begin
                if (bus.abort) begin
                    state_next = IDLE;
                    flush      = 1'b1;
                end else begin
                    init_scan  = 1'b1;
                    state_next = (row_ok && row_any) ? RUN : FIN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                    flush      = 1'b1;
                end else if (valid_q && bus.out_ready && last_q) begin
                    state_next = FIN;
                    flush      = 1'b1;
                end else begin
                    // A pending last beat parks the scan so nothing past the row end is visited
                    scan = !valid_q || (bus.out_ready && !last_q);
                end
            end
            FIN: begin
                state_next = IDLE;
                fin_pulse  = !bus.abort;
            end
            default: state_next = IDLE;
        endcase
    end

    // Scan counters, output register and done/err pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            sub      <= '0;
            bcol     <= '0;
            base     <= '0;
            err_flag <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            bcol_q   <= '0;
            sub_q    <= '0;
            shift_q  <= '0;
            col_q    <= '0;
        end else begin
            done_q <= fin_pulse;
            err_q  <= fin_pulse && err_flag;
            if (load_row) begin
                row <= bus.row_sel;
            end
            if (init_scan) begin
                sub      <= '0;
                bcol     <= '0;
                base     <= '0;
                err_flag <= !(row_ok && row_any);
            end
            if (flush) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (scan) begin
                valid_q <= cur_present;
                last_q  <= cur_present && (sub == SUB_MAX) && (bcol == last_bcol);
                if (cur_present) begin
                    bcol_q  <= bcol;
                    sub_q   <= sub;
                    shift_q <= cur_shift;
                    col_q   <= col_next;
                end
                if (bcol == BCOL_MAX) begin
                    bcol <= '0;
                    base <= '0;
                    sub  <= sub + SHIFT_W'(1);
                end else begin
                    bcol <= bcol + BCOL_W'(1);
                    base <= base + Z_COL;
                end
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.out_valid = valid_q;
    assign bus.out_bcol  = bcol_q;
    assign bus.out_sub   = sub_q;
    assign bus.out_shift = shift_q;
    assign bus.out_col   = col_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_qc_ldpc_row_expander.sv
// Self-checking bench for qc_ldpc_row_expander: default 512x18x2 table,
// a NB_ROW=1 all-absent table for the error path, and a Z=5 two-column table.
module tb_qc_ldpc_row_expander;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qc_ldpc_row_expander_if #(.ROW_W(1), .SHIFT_W(9), .COL_W(14), .BCOL_W(5)) bus ();
    qc_ldpc_row_expander_if #(.ROW_W(1), .SHIFT_W(9), .COL_W(14), .BCOL_W(5)) bus_nr ();
    qc_ldpc_row_expander_if #(.ROW_W(1), .SHIFT_W(3), .COL_W(4), .BCOL_W(1)) bus_s ();

    qc_ldpc_row_expander #(
        .Z(512), .SHIFT_W(9), .NB_COL(18), .NB_ROW(2), .ROW_W(1), .COL_W(14), .BCOL_W(5)
    ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    qc_ldpc_row_expander #(
        .Z(512), .SHIFT_W(9), .NB_COL(18), .NB_ROW(1), .ROW_W(1), .COL_W(14), .BCOL_W(5),
        .TABLE('0)
    ) u_dut_nr (.clk(clk), .rst_n(rst_n), .bus(bus_nr));

    qc_ldpc_row_expander #(
        .Z(5), .SHIFT_W(3), .NB_COL(2), .NB_ROW(1), .ROW_W(1), .COL_W(4), .BCOL_W(1),
        .TABLE(8'b0000_1011)
    ) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    int tab [2][18] = '{
        '{122, 0, 10, 151, 501, 310, 465, 474, 21, 52, 69, 218, 487, 90, 332, 128, 167, 110},
        '{381, 367, 370, 143, 54, 16, 511, 175, 447, 329, 213, 179, 463, 91, 394, 219, 134, 32}
    };

    int n_vec = 0;
    int n_err = 0;

    logic [37:0] exp_q [$];
    logic [37:0] got_q [$];
    int hold_err, done_gap;
    bit done_seen, done_err, done_busy;

    function automatic logic [37:0] pack(int last, int bcol, int sub, int shift, int col);
        logic [37:0] v;
        v = {1'(last), 5'(bcol), 9'(sub), 9'(shift), 14'(col)};
        return v;
    endfunction

    function automatic logic [37:0] cur_beat();
        return {bus.out_last, bus.out_bcol, bus.out_sub, bus.out_shift, bus.out_col};
    endfunction

    function automatic logic [37:0] got_at(int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    // Reference: every sub-row, every block column, column = b*Z + (shift+sub) mod Z
    task automatic build_model(input int r);
        logic [37:0] tmp;
        exp_q.delete();
        for (int s = 0; s < 512; s++)
            for (int b = 0; b < 18; b++)
                exp_q.push_back(pack(0, b, s, tab[r][b], b * 512 + (tab[r][b] + s) % 512));
        tmp = exp_q.pop_back();
        tmp[37] = 1'b1;
        exp_q.push_back(tmp);
    endtask

    function automatic int seq_mism(output int first);
        int m;
        m = 0;
        first = -1;
        if (got_q.size() != exp_q.size()) begin
            m = 1;
            first = -2;
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (first < 0) first = i;
                m++;
            end
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_row(input int r);
        bus.row_sel = 1'(r);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Gathers accepted beats until done; tracks output stability while stalled
    task automatic collect(input bit rand_ready, input int max_cycles);
        bit stall, r;
        logic [37:0] held;
        int last_cyc;
        got_q.delete();
        hold_err = 0; done_seen = 0; done_err = 0; done_busy = 1; done_gap = -1;
        stall = 0; last_cyc = 0; held = '0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (stall && (cur_beat() !== held || bus.out_valid !== 1'b1)) hold_err++;
            if (bus.done) begin
                done_seen = 1; done_err = bus.err; done_busy = bus.busy;
                done_gap = cyc - last_cyc;
                break;
            end
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = r;
            if (bus.out_valid && r) begin
                got_q.push_back(cur_beat());
                last_cyc = cyc;
            end
            stall = bus.out_valid && !r;
            held = cur_beat();
            step();
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [41:0] v;
        repeat (3) @(posedge clk);
        #1;
        v = {bus.out_valid, bus.busy, bus.done, bus.err, cur_beat()};
        n_vec++;
        if (v !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got %h expected 0", v);
        end
        rst_n = 1'b1;
        step();
        v = {bus.out_valid, bus.busy, bus.done, bus.err, cur_beat()};
        n_vec++;
        if (v !== '0) begin
            n_err++;
            $display("FAIL reset_release: got %h expected 0", v);
        end
    endtask

    task automatic test_row0();
        int m, first;
        build_model(0);
        start_row(0);
        n_vec++;
        if ({bus.busy, bus.out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL r0_busy_rise: got %b expected 10", {bus.busy, bus.out_valid});
        end
        step();
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL r0_no_early_beat: got %b expected 0", bus.out_valid);
        end
        step();
        n_vec++;
        if ({bus.out_valid, cur_beat()} !== {1'b1, pack(0, 0, 0, 122, 122)}) begin
            n_err++;
            $display("FAIL r0_first_beat: got %h expected %h", {bus.out_valid, cur_beat()},
                     {1'b1, pack(0, 0, 0, 122, 122)});
        end
        collect(1'b0, 12000);
        n_vec++;
        if (got_q.size() !== 9216) begin
            n_err++;
            $display("FAIL r0_count: got %0d expected 9216", got_q.size());
        end
        n_vec++;
        if (got_at(1) !== pack(0, 1, 0, 0, 512)) begin
            n_err++;
            $display("FAIL r0_beat1: got %h expected %h", got_at(1), pack(0, 1, 0, 0, 512));
        end
        n_vec++;
        if (got_at(18) !== pack(0, 0, 1, 122, 123)) begin
            n_err++;
            $display("FAIL r0_beat18: got %h expected %h", got_at(18), pack(0, 0, 1, 122, 123));
        end
        n_vec++;
        if (got_at(9215) !== pack(1, 17, 511, 110, 8813)) begin
            n_err++;
            $display("FAIL r0_last: got %h expected %h", got_at(9215), pack(1, 17, 511, 110, 8813));
        end
        m = seq_mism(first);
        n_vec++;
        if (m !== 0) begin
            n_err++;
            $display("FAIL r0_sequence: got %0d bad beats (first %0d) expected 0", m, first);
        end
        n_vec++;
        if ({done_seen, done_err, done_busy, 8'(done_gap)} !== {3'b100, 8'd2}) begin
            n_err++;
            $display("FAIL r0_done: got seen=%0d err=%0d busy=%0d gap=%0d expected 1 0 0 2",
                     done_seen, done_err, done_busy, done_gap);
        end
        step();
        n_vec++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL r0_done_pulse: got %b expected 00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_row1();
        int m, first;
        build_model(1);
        start_row(1);
        collect(1'b0, 12000);
        n_vec++;
        if (got_at(0) !== pack(0, 0, 0, 381, 381)) begin
            n_err++;
            $display("FAIL r1_beat0: got %h expected %h", got_at(0), pack(0, 0, 0, 381, 381));
        end
        n_vec++;
        if (got_at(24) !== pack(0, 6, 1, 511, 3072)) begin
            n_err++;
            $display("FAIL r1_wrap_bcol6: got %h expected %h", got_at(24), pack(0, 6, 1, 511, 3072));
        end
        n_vec++;
        if (got_at(2358) !== pack(0, 0, 131, 381, 0)) begin
            n_err++;
            $display("FAIL r1_sub131: got %h expected %h", got_at(2358), pack(0, 0, 131, 381, 0));
        end
        m = seq_mism(first);
        n_vec++;
        if (m !== 0) begin
            n_err++;
            $display("FAIL r1_sequence: got %0d bad beats (first %0d) expected 0", m, first);
        end
        n_vec++;
        if ({done_seen, done_err} !== 2'b10) begin
            n_err++;
            $display("FAIL r1_done: got %b expected 10", {done_seen, done_err});
        end
    endtask

    task automatic test_random_ready();
        int m, first;
        build_model(0);
        start_row(0);
        collect(1'b1, 40000);
        m = seq_mism(first);
        n_vec++;
        if (m !== 0) begin
            n_err++;
            $display("FAIL rr_sequence: got %0d bad beats (first %0d, n=%0d) expected 0",
                     m, first, got_q.size());
        end
        n_vec++;
        if (hold_err !== 0) begin
            n_err++;
            $display("FAIL rr_hold_stable: got %0d changes while stalled expected 0", hold_err);
        end
        n_vec++;
        if ({done_seen, done_err} !== 2'b10) begin
            n_err++;
            $display("FAIL rr_done: got %b expected 10", {done_seen, done_err});
        end
    endtask

    task automatic test_error();
        logic [3:0] seq [4];
        for (int r = 1; r >= 0; r--) begin
            bus_nr.row_sel = 1'(r);
            bus_nr.start = 1'b1;
            step();
            bus_nr.start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                seq[k] = {bus_nr.busy, bus_nr.done, bus_nr.err, bus_nr.out_valid};
                if (k < 3) step();
            end
            n_vec++;
            if ({seq[0], seq[1], seq[2], seq[3]} !== 16'b1000_1000_0110_0000) begin
                n_err++;
                $display("FAIL err_row%0d: got %b %b %b %b expected 1000 1000 0110 0000",
                         r, seq[0], seq[1], seq[2], seq[3]);
            end
        end
    endtask

    task automatic test_abort_reset();
        int n, mism, seen;
        build_model(0);
        start_row(0);
        step();
        step();
        n = 0; mism = 0;
        for (int cyc = 0; cyc < 400 && n < 100; cyc++) begin
            if (n == 50) begin
                bus.row_sel = 1'b1;
                bus.start = 1'b1;
            end
            if (bus.out_valid) begin
                if (cur_beat() !== exp_q[n]) mism++;
                n++;
            end
            step();
            bus.start = 1'b0;
        end
        n_vec++;
        if ({16'(n), 16'(mism)} !== {16'd100, 16'd0}) begin
            n_err++;
            $display("FAIL ab_pre_beats: got n=%0d bad=%0d expected n=100 bad=0", n, mism);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        n_vec++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL ab_idle: got %b expected 00", {bus.out_valid, bus.busy});
        end
        seen = 0;
        repeat (6) begin
            step();
            if (bus.done || bus.out_valid) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL ab_quiet: got %0d active cycles expected 0", seen);
        end
        start_row(0);
        step();
        step();
        n_vec++;
        if ({bus.out_valid, cur_beat()} !== {1'b1, exp_q[0]}) begin
            n_err++;
            $display("FAIL ab_restart: got %h expected %h", {bus.out_valid, cur_beat()}, {1'b1, exp_q[0]});
        end
        n = 0;
        for (int cyc = 0; cyc < 1000 && n < 500; cyc++) begin
            if (bus.out_valid) n++;
            if (n < 500) step();
        end
        n_vec++;
        if (n !== 500) begin
            n_err++;
            $display("FAIL rs_reach_500: got %0d expected 500", n);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.busy, bus.done, bus.err, cur_beat()} !== '0) begin
            n_err++;
            $display("FAIL rs_async_clear: got %h expected 0",
                     {bus.out_valid, bus.busy, bus.done, bus.err, cur_beat()});
        end
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            step();
            if (bus.done || bus.out_valid || bus.busy) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL rs_no_stale: got %0d active cycles expected 0", seen);
        end
        start_row(0);
        step();
        step();
        n_vec++;
        if ({bus.out_valid, cur_beat()} !== {1'b1, exp_q[0]}) begin
            n_err++;
            $display("FAIL rs_restart: got %h expected %h", {bus.out_valid, cur_beat()}, {1'b1, exp_q[0]});
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
    endtask

    task automatic test_small();
        int cols [$];
        int cycs [$];
        int lasts, last_sub, bad_gap;
        bit fin;
        bus_s.row_sel = 1'b0;
        bus_s.start = 1'b1;
        step();
        bus_s.start = 1'b0;
        lasts = 0; last_sub = -1; fin = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (bus_s.done) begin
                fin = 1;
                break;
            end
            if (bus_s.out_valid) begin
                cols.push_back(int'(bus_s.out_col));
                cycs.push_back(cyc);
                lasts = (lasts << 1) | int'(bus_s.out_last);
                if (bus_s.out_last) last_sub = int'(bus_s.out_sub);
            end
            step();
        end
        n_vec++;
        if (cols.size() !== 5 || cols != '{3, 4, 0, 1, 2}) begin
            n_err++;
            $display("FAIL sm_cols: got %p expected '{3, 4, 0, 1, 2}", cols);
        end
        bad_gap = 0;
        for (int i = 1; i < cycs.size(); i++) if (cycs[i] - cycs[i-1] != 2) bad_gap++;
        n_vec++;
        if (bad_gap !== 0) begin
            n_err++;
            $display("FAIL sm_bubbles: got %0d wrong beat spacings expected 0", bad_gap);
        end
        n_vec++;
        if ({8'(lasts), 8'(last_sub), fin} !== {8'b00001, 8'd4, 1'b1}) begin
            n_err++;
            $display("FAIL sm_last: got flags=%b sub=%0d done=%0d expected 00001 4 1", lasts, last_sub, fin);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;    bus.abort = 1'b0;    bus.row_sel = '0;    bus.out_ready = 1'b1;
        bus_nr.start = 1'b0; bus_nr.abort = 1'b0; bus_nr.row_sel = '0; bus_nr.out_ready = 1'b1;
        bus_s.start = 1'b0;  bus_s.abort = 1'b0;  bus_s.row_sel = '0;  bus_s.out_ready = 1'b1;
        test_reset();
        test_row0();
        test_row1();
        test_random_ready();
        test_error();
        test_abort_reset();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
